// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: three result sources (ALU/link, load return, muldiv)
// share the single register-file write port. Fixed priority s0 > s1 > s2, with
// starvation promotion for s1/s2 and a registered writeback stage.
module wb_port_arbiter #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CW           = 8
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             s0_valid,
    input  logic [4:0]       s0_rd,
    input  logic [WIDTH-1:0] s0_data,
    output logic             s0_ready,

    input  logic             s1_valid,
    input  logic [4:0]       s1_rd,
    input  logic [WIDTH-1:0] s1_data,
    output logic             s1_ready,

    input  logic             s2_valid,
    input  logic [4:0]       s2_rd,
    input  logic [WIDTH-1:0] s2_data,
    output logic             s2_ready,

    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic [1:0]       wb_src
);

    // Same encoding as the result-select control.
    localparam logic [1:0] SrcAlu = 2'b00;
    localparam logic [1:0] SrcMem = 2'b01;
    localparam logic [1:0] SrcMdu = 2'b10;

    localparam logic [CW-1:0] Limit = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt1_q, cnt1_d;
    logic [CW-1:0] cnt2_q, cnt2_d;

    logic st1, st2;
    logic gnt0, gnt1, gnt2;
    logic xfer;

    logic             wb_we_q,   wb_we_d;
    logic [4:0]       wb_rd_q,   wb_rd_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic [1:0]       wb_src_q,  wb_src_d;

    assign st1 = (cnt1_q == Limit);
    assign st2 = (cnt2_q == Limit);

    // Grant: promoted s1, promoted s2, then plain s0 > s1 > s2; nothing during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        gnt2 = 1'b0;
        if (!reset) begin
            if (st1 && s1_valid) begin
                gnt1 = 1'b1;
            end else if (st2 && s2_valid) begin
                gnt2 = 1'b1;
            end else if (s0_valid) begin
                gnt0 = 1'b1;
            end else if (s1_valid) begin
                gnt1 = 1'b1;
            end else if (s2_valid) begin
                gnt2 = 1'b1;
            end
        end
    end

    assign s0_ready = gnt0;
    assign s1_ready = gnt1;
    assign s2_ready = gnt2;
    assign xfer     = gnt0 | gnt1 | gnt2;

    // Starvation counters: count consecutive denied cycles, saturating at the limit.
    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (!s1_valid || gnt1) begin
            cnt1_d = '0;
        end else if (cnt1_q != Limit) begin
            cnt1_d = cnt1_q + CW'(1);
        end
        if (!s2_valid || gnt2) begin
            cnt2_d = '0;
        end else if (cnt2_q != Limit) begin
            cnt2_d = cnt2_q + CW'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    // Writeback next state: load the winner; otherwise drop we and hold the rest.
    always_comb begin
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        wb_src_d  = wb_src_q;
        if (gnt0) begin
            wb_rd_d   = s0_rd;
            wb_data_d = s0_data;
            wb_src_d  = SrcAlu;
        end else if (gnt1) begin
            wb_rd_d   = s1_rd;
            wb_data_d = s1_data;
            wb_src_d  = SrcMem;
        end else if (gnt2) begin
            wb_rd_d   = s2_rd;
            wb_data_d = s2_data;
            wb_src_d  = SrcMdu;
        end
        // x0 writes complete the handshake but never reach the register file.
        if (xfer) begin
            wb_we_d = (wb_rd_d != 5'd0);
        end
    end

    // Writeback output register; reset discards any transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_src_q  <= SrcAlu;
        end else begin
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_src_q  <= wb_src_d;
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;
    assign wb_src  = wb_src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic, checked
// against a request/age reference model with a writeback scoreboard.
module tb_wb_port_arbiter;

    localparam int unsigned W     = 32;
    localparam int unsigned LIMIT = 4;

    typedef struct packed {
        logic         we;
        logic [4:0]   rd;
        logic [W-1:0] data;
        logic [1:0]   src;
    } wb_t;

    logic         clk;
    logic         reset;
    logic         s0_valid, s1_valid, s2_valid;
    logic [4:0]   s0_rd, s1_rd, s2_rd;
    logic [W-1:0] s0_data, s1_data, s2_data;
    logic         s0_ready, s1_ready, s2_ready;
    logic         wb_we;
    logic [4:0]   wb_rd;
    logic [W-1:0] wb_data;
    logic [1:0]   wb_src;

    wb_port_arbiter #(
        .WIDTH       (W),
        .STARVE_LIMIT(LIMIT),
        .CW          (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s0_valid(s0_valid),
        .s0_rd   (s0_rd),
        .s0_data (s0_data),
        .s0_ready(s0_ready),
        .s1_valid(s1_valid),
        .s1_rd   (s1_rd),
        .s1_data (s1_data),
        .s1_ready(s1_ready),
        .s2_valid(s2_valid),
        .s2_rd   (s2_rd),
        .s2_data (s2_data),
        .s2_ready(s2_ready),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .wb_src  (wb_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: pending request per source plus how many cycles it has waited.
    logic         act  [3];
    logic [4:0]   rdv  [3];
    logic [W-1:0] datv [3];
    int           age  [3];

    wb_t exp_q[$];
    logic mon_on = 1'b0;

    // One cycle: present the sources, predict the grant, check, advance the model.
    task automatic step(input logic rst);
        int   g;
        logic [2:0] exp_rdy, got_rdy;
        wb_t  e;
        reset    = rst;
        s0_valid = act[0]; s0_rd = rdv[0]; s0_data = datv[0];
        s1_valid = act[1]; s1_rd = rdv[1]; s1_data = datv[1];
        s2_valid = act[2]; s2_rd = rdv[2]; s2_data = datv[2];
        g = -1;
        if (!rst) begin
            if (act[1] && age[1] >= LIMIT)      g = 1;
            else if (act[2] && age[2] >= LIMIT) g = 2;
            else if (act[0])                    g = 0;
            else if (act[1])                    g = 1;
            else if (act[2])                    g = 2;
        end
        #3;
        exp_rdy = 3'b000;
        if (g >= 0) exp_rdy[g] = 1'b1;
        got_rdy = {s2_ready, s1_ready, s0_ready};
        total++;
        if ($isunknown(got_rdy)) begin
            bad++;
            $display("FAIL ready_x: got %b required known value", got_rdy);
        end
        total++;
        if (got_rdy !== exp_rdy) begin
            bad++;
            $display("FAIL ready @%0t: got %b required %b", $time, got_rdy, exp_rdy);
        end
        if (g >= 0) begin
            e.we   = (rdv[g] != 5'd0);
            e.rd   = rdv[g];
            e.data = datv[g];
            e.src  = 2'(g);
            exp_q.push_back(e);
        end
        for (int s = 0; s < 3; s++) begin
            if (rst || !act[s] || g == s) age[s] = 0;
            else                          age[s] = age[s] + 1;
        end
        if (g >= 0) act[g] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int s, input logic [4:0] rd, input logic [W-1:0] d);
        act[s]  = 1'b1;
        rdv[s]  = rd;
        datv[s] = d;
    endtask

    // Monitor: the cycle after each observed transfer, the writeback must match the next entry.
    initial begin
        logic prev_rst, prev_xfer;
        wb_t  last, e;
        prev_rst  = 1'b0;
        prev_xfer = 1'b0;
        last      = '0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (prev_rst) begin
                    total++;
                    if ({wb_we, wb_rd, wb_data, wb_src} !== '0) begin
                        bad++;
                        $display("FAIL wb_after_reset: got we=%b rd=%0d data=%h src=%b required all 0",
                                 wb_we, wb_rd, wb_data, wb_src);
                    end
                    last = '0;
                end else if (prev_xfer) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL wb_unexpected: got we=%b rd=%0d required no transfer",
                                 wb_we, wb_rd);
                    end else begin
                        e = exp_q.pop_front();
                        if ({wb_we, wb_rd, wb_data, wb_src} !== e) begin
                            bad++;
                            $display("FAIL wb: got we=%b rd=%0d data=%h src=%b required we=%b rd=%0d data=%h src=%b",
                                     wb_we, wb_rd, wb_data, wb_src, e.we, e.rd, e.data, e.src);
                        end
                        last = e;
                    end
                end else begin
                    total++;
                    if ({wb_we, wb_rd, wb_data, wb_src} !== {1'b0, last.rd, last.data, last.src}) begin
                        bad++;
                        $display("FAIL wb_hold: got we=%b rd=%0d data=%h src=%b required we=0 rd=%0d data=%h src=%b",
                                 wb_we, wb_rd, wb_data, wb_src, last.rd, last.data, last.src);
                    end
                end
            end
            prev_rst  = reset;
            prev_xfer = !reset && ((s0_valid && s0_ready) || (s1_valid && s1_ready) ||
                                   (s2_valid && s2_ready));
        end
    end

    initial begin
        for (int s = 0; s < 3; s++) begin
            act[s] = 1'b0; rdv[s] = '0; datv[s] = '0; age[s] = 0;
        end
        reset = 1'b1;
        s0_valid = 1'b0; s1_valid = 1'b0; s2_valid = 1'b0;
        s0_rd = '0; s1_rd = '0; s2_rd = '0;
        s0_data = '0; s1_data = '0; s2_data = '0;
        @(posedge clk);
        #1;
        step(1'b1);
        mon_on = 1'b1;
        step(1'b1);
        step(1'b0);

        // Single s0 write.
        req(0, 5'd5, 32'h0000_1234);
        step(1'b0); step(1'b0); step(1'b0);

        // All three at once: s0, s1, s2 on consecutive cycles.
        req(0, 5'd1, 32'h1111_0001);
        req(1, 5'd2, 32'h2222_0002);
        req(2, 5'd3, 32'h3333_0003);
        for (int i = 0; i < 5; i++) step(1'b0);

        // s0 continuous, s2 starves until promoted after LIMIT denied cycles.
        req(2, 5'd9, 32'hA5A5_0009);
        for (int i = 0; i < 10; i++) begin
            if (!act[0]) req(0, 5'(i + 10), 32'h0C00_0000 + 32'(i));
            step(1'b0);
        end

        // s0 continuous, s1 and s2 starve together: s1 first, then s2.
        req(1, 5'd17, 32'h0000_0017);
        req(2, 5'd18, 32'h0000_0018);
        for (int i = 0; i < 10; i++) begin
            if (!act[0]) req(0, 5'(i + 1), 32'h0D00_0000 + 32'(i));
            step(1'b0);
        end
        act[0] = 1'b0;
        step(1'b0);

        // s1 with rd = 0: handshake completes, no write.
        req(1, 5'd0, 32'hDEAD_BEEF);
        step(1'b0); step(1'b0); step(1'b0);

        // Reset while s2 has waited 3 cycles and s0 is transferring.
        req(2, 5'd21, 32'h0000_0021);
        for (int i = 0; i < 3; i++) begin
            if (!act[0]) req(0, 5'(i + 4), 32'h0E00_0000 + 32'(i));
            step(1'b0);
        end
        if (!act[0]) req(0, 5'd30, 32'h0E00_00FF);
        step(1'b1);
        for (int i = 0; i < 10; i++) begin
            if (!act[0]) req(0, 5'(i + 8), 32'h0F00_0000 + 32'(i));
            step(1'b0);
        end
        act[0] = 1'b0;
        step(1'b0); step(1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if (!act[0] && $urandom_range(0, 99) < 70) req(0, 5'($urandom_range(0, 31)), $urandom);
            if (!act[1] && $urandom_range(0, 99) < 35) req(1, 5'($urandom_range(0, 31)), $urandom);
            if (!act[2] && $urandom_range(0, 99) < 25) req(2, 5'($urandom_range(0, 31)), $urandom);
            step($urandom_range(0, 99) < 2);
        end

        // Drain: bounded number of idle cycles.
        for (int i = 0; i < 20 && (act[0] || act[1] || act[2]); i++) step(1'b0);
        for (int s = 0; s < 3; s++) act[s] = 1'b0;
        step(1'b0); step(1'b0);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending writebacks required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
